// File: rtl/inv_round_key_block.sv
// inv_round_key_block: stores AES-128 round keys 0..NUM_ROUNDS and applies them in reverse order to inverse-cipher states
//   clk, rst                : clock, asynchronous active-high reset
//   key_load_start          : discard stored keys, begin a new load
//   round_key/_vld          : ascending-order round keys from key expansion
//   keys_loaded             : all NUM_ROUNDS+1 keys present
//   data_in/_vld, data_first: inverse-cipher state, valid, first-state-of-block flag
//   block_data_out/_vld     : data_in XOR selected key, one cycle later
//   round_idx_out           : key index used for block_data_out
//   block_done              : output used key 0
//   key_miss                : data arrived before keys were loaded
module inv_round_key_block #(
    parameter int BLOCK_DATA_WIDTH = 128,
    parameter int SEED_KEY_WIDTH   = 128,
    parameter int NUM_ROUNDS       = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_load_start,
    input  logic [SEED_KEY_WIDTH-1:0]   round_key,
    input  logic                        round_key_vld,
    output logic                        keys_loaded,
    input  logic [BLOCK_DATA_WIDTH-1:0] data_in,
    input  logic                        data_in_vld,
    input  logic                        data_first,
    output logic [BLOCK_DATA_WIDTH-1:0] block_data_out,
    output logic                        block_data_out_vld,
    output logic [3:0]                  round_idx_out,
    output logic                        block_done,
    output logic                        key_miss
);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {EMPTY, LOADING, READY, DECRYPT} state_t;

    state_t                    state;
    logic [3:0]                wr_ptr;
    logic [3:0]                rd_idx;
    logic [3:0]                use_idx;
    logic                      wr_en;
    logic [SEED_KEY_WIDTH-1:0] keys [0:NUM_ROUNDS];

    // A load restart drops any key arriving in the same cycle; a full store is never overwritten.
    assign wr_en   = round_key_vld && !key_load_start && (state == EMPTY || state == LOADING);
    // Outside a block every state starts at the last key, whatever data_first says.
    assign use_idx = (data_first || state == READY) ? LAST : rd_idx;

    always_ff @(posedge clk) begin
        if (wr_en) keys[wr_ptr] <= round_key;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= EMPTY;
            wr_ptr             <= '0;
            rd_idx             <= LAST;
            keys_loaded        <= 1'b0;
            block_data_out     <= '0;
            block_data_out_vld <= 1'b0;
            round_idx_out      <= '0;
            block_done         <= 1'b0;
            key_miss           <= 1'b0;
        end else begin
            block_data_out_vld <= data_in_vld;
            key_miss           <= data_in_vld && !keys_loaded;
            block_done         <= 1'b0;
            if (wr_en) begin
                wr_ptr      <= wr_ptr + 4'd1;
                state       <= (wr_ptr == LAST) ? READY : LOADING;
                keys_loaded <= (wr_ptr == LAST);
            end
            // keys_loaded implies READY/DECRYPT, so this never collides with a key write.
            if (data_in_vld) begin
                if (keys_loaded) begin
                    block_data_out <= data_in ^ keys[use_idx];
                    round_idx_out  <= use_idx;
                    block_done     <= (use_idx == 4'd0) && !key_load_start;
                    rd_idx         <= (use_idx == 4'd0) ? LAST : use_idx - 4'd1;
                    state          <= (use_idx == 4'd0) ? READY : DECRYPT;
                end else begin
                    block_data_out <= '0;
                    round_idx_out  <= '0;
                end
            end
            if (key_load_start) begin
                state       <= LOADING;
                wr_ptr      <= '0;
                rd_idx      <= LAST;
                keys_loaded <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_inv_round_key_block.sv
// tb_inv_round_key_block: directed checks of key load, reverse-order key application and abort paths
module tb_inv_round_key_block;
    logic         clk = 1'b0;
    logic         rst;
    logic         key_load_start;
    logic [127:0] round_key;
    logic         round_key_vld;
    logic         keys_loaded;
    logic [127:0] data_in;
    logic         data_in_vld;
    logic         data_first;
    logic [127:0] block_data_out;
    logic         block_data_out_vld;
    logic [3:0]   round_idx_out;
    logic         block_done;
    logic         key_miss;
    int           n_checks = 0;
    int           n_fails  = 0;

    inv_round_key_block dut (
        .clk(clk), .rst(rst), .key_load_start(key_load_start),
        .round_key(round_key), .round_key_vld(round_key_vld), .keys_loaded(keys_loaded),
        .data_in(data_in), .data_in_vld(data_in_vld), .data_first(data_first),
        .block_data_out(block_data_out), .block_data_out_vld(block_data_out_vld),
        .round_idx_out(round_idx_out), .block_done(block_done), .key_miss(key_miss)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] key(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {16{b}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [127:0] d,
                           input logic [3:0] idx, input logic done, input logic miss);
        chk({tag, ".vld"}, 128'(block_data_out_vld), 128'(vld));
        chk({tag, ".data"}, block_data_out, d);
        chk({tag, ".idx"}, 128'(round_idx_out), 128'(idx));
        chk({tag, ".done"}, 128'(block_done), 128'(done));
        chk({tag, ".miss"}, 128'(key_miss), 128'(miss));
    endtask

    task automatic send(input logic first, input logic [127:0] d);
        data_in_vld = 1'b1;
        data_first  = first;
        data_in     = d;
        cyc();
        data_in_vld = 1'b0;
        data_first  = 1'b0;
    endtask

    task automatic load_keys(input logic miss_on_last);
        for (int i = 0; i <= 10; i++) begin
            round_key     = key(i);
            round_key_vld = 1'b1;
            data_in_vld   = miss_on_last && i == 10;
            data_in       = '1;
            cyc();
            chk($sformatf("load%0d.loaded", i), 128'(keys_loaded), 128'(i == 10));
        end
        round_key_vld = 1'b0;
        data_in_vld   = 1'b0;
    endtask

    initial begin
        logic [127:0] pat;
        rst = 1'b1; key_load_start = 1'b0; round_key = '0; round_key_vld = 1'b0;
        data_in = '0; data_in_vld = 1'b0; data_first = 1'b0;
        cyc();
        chk("reset.loaded", 128'(keys_loaded), 128'd0);
        chk_out("reset", 1'b0, '0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc();

        send(1'b1, '1);
        chk_out("early_miss", 1'b1, '0, 4'd0, 1'b0, 1'b1);
        cyc();
        chk("idle.vld", 128'(block_data_out_vld), 128'd0);
        chk("idle.miss", 128'(key_miss), 128'd0);

        load_keys(1'b0);
        round_key = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
        round_key_vld = 1'b1;
        cyc();
        round_key_vld = 1'b0;
        chk("ignored_key.loaded", 128'(keys_loaded), 128'd1);

        for (int i = 0; i <= 10; i++) begin
            send(i == 0, '0);
            chk_out($sformatf("blk_a%0d", i), 1'b1, key(10 - i), 4'(10 - i), i == 10, 1'b0);
        end
        cyc();
        chk("hold.vld", 128'(block_data_out_vld), 128'd0);
        chk("hold.data", block_data_out, key(0));

        pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int i = 0; i < 5; i++) begin
            send(i == 0, pat);
            chk_out($sformatf("blk_b%0d", i), 1'b1, pat ^ key(10 - i), 4'(10 - i), 1'b0, 1'b0);
        end
        send(1'b1, pat);
        chk_out("restart", 1'b1, pat ^ key(10), 4'd10, 1'b0, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            send(1'b0, pat);
            chk_out($sformatf("blk_c%0d", i), 1'b1, pat ^ key(i), 4'(i), i == 0, 1'b0);
        end

        for (int i = 0; i < 4; i++) send(i == 0, pat);
        key_load_start = 1'b1;
        cyc();
        key_load_start = 1'b0;
        chk("abort.loaded", 128'(keys_loaded), 128'd0);
        chk("abort.done", 128'(block_done), 128'd0);
        send(1'b0, pat);
        chk_out("abort_miss", 1'b1, '0, 4'd0, 1'b0, 1'b1);

        load_keys(1'b1);
        chk("last_write_miss", 128'(key_miss), 128'd1);
        send(1'b0, pat);
        chk_out("ready_first", 1'b1, pat ^ key(10), 4'd10, 1'b0, 1'b0);
        send(1'b0, pat);
        chk_out("ready_next", 1'b1, pat ^ key(9), 4'd9, 1'b0, 1'b0);

        data_in_vld = 1'b1;
        data_in     = pat;
        cyc();
        rst = 1'b1;
        #1;
        chk("async_rst.loaded", 128'(keys_loaded), 128'd0);
        chk_out("async_rst", 1'b0, '0, 4'd0, 1'b0, 1'b0);
        data_in_vld = 1'b0;
        cyc();
        rst = 1'b0;
        send(1'b0, pat);
        chk_out("post_rst_miss", 1'b1, '0, 4'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/inv_round_key_block.md
Name: inv_round_key_block

Overview:
Decrypt-side round-key store and add-round-key stage for the AES-128 datapath. The forward key expansion writes round keys 0..10 in order. This block buffers them and applies them in reverse order (10 down to 0) to successive inverse-cipher states. Sits between the key expansion and the inverse round datapath, and serves as the decrypt counterpart of the forward add-round-key stage.

Parameters:
BLOCK_DATA_WIDTH, 128, state/data width in bits
SEED_KEY_WIDTH, 128, round key width in bits; must equal BLOCK_DATA_WIDTH
NUM_ROUNDS, 10, cipher rounds; the store holds NUM_ROUNDS+1 keys

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
key_load_start  input  1  pulse: discard stored keys and begin a new load
round_key  input  SEED_KEY_WIDTH  round key from key expansion, in ascending round order
round_key_vld  input  1  round_key valid this cycle
keys_loaded  output  1  all NUM_ROUNDS+1 keys stored
data_in  input  BLOCK_DATA_WIDTH  inverse-cipher state
data_in_vld  input  1  data_in valid this cycle
data_first  input  1  qualifies data_in_vld: first state of a new block (uses key NUM_ROUNDS)
block_data_out  output  BLOCK_DATA_WIDTH  data_in XOR selected round key, registered
block_data_out_vld  output  1  block_data_out valid
round_idx_out  output  4  key index applied to the current block_data_out
block_done  output  1  pulse with the output that used key 0
key_miss  output  1  pulse: data_in_vld accepted while keys_loaded=0

Behaviour:
- Reset values: all outputs 0, wr_ptr=0, rd_idx=NUM_ROUNDS, state EMPTY. Key storage contents are don't-care and need no reset.
- States: EMPTY -> LOADING on key_load_start or the first round_key_vld. LOADING -> READY when key NUM_ROUNDS is written. READY <-> DECRYPT per block.
- Write side: on each round_key_vld in EMPTY/LOADING, store round_key at wr_ptr and increment wr_ptr. keys_loaded rises the cycle after the write of index NUM_ROUNDS. round_key_vld in READY/DECRYPT is ignored; there is no overwrite.
- key_load_start in any state:
  - clears keys_loaded, sets wr_ptr=0, rd_idx=NUM_ROUNDS;
  - aborts any block in progress (no block_done);
  - takes priority over a round_key_vld in the same cycle, so that key is dropped.
- Read side, when data_in_vld=1 and keys_loaded=1:
  - data_first=1: use key NUM_ROUNDS, then set rd_idx=NUM_ROUNDS-1, enter DECRYPT.
  - data_first=0 in DECRYPT: use key rd_idx, then decrement rd_idx.
  - Using key 0 asserts block_done with that output, wraps rd_idx to NUM_ROUNDS, returns to READY.
  - data_first=1 in DECRYPT restarts the block at key NUM_ROUNDS; no block_done for the abandoned block.
  - data_first=0 in READY is treated as data_first=1.
- Latency: 1 cycle. block_data_out/block_data_out_vld/round_idx_out register on the edge after data_in_vld. block_data_out_vld=0 on cycles without data_in_vld, and block_data_out holds its last value.
- Key-not-ready case: data_in_vld with keys_loaded=0 gives block_data_out=0, block_data_out_vld=1, key_miss=1 next cycle, and no rd_idx change.
- Simultaneous last key write and data_in_vld: keys_loaded is not yet 1, so this is a key_miss case.
- Full throughput: one state per cycle; no back-pressure.
- Reset asserted mid-block returns all outputs and pointers to reset values immediately.

Test Plan:
- Load keys K0..K10 (Ki = {16{i[7:0]}}), one per cycle -> keys_loaded=1 the cycle after K10 write; round_key_vld afterwards leaves the store unchanged.
- Eleven consecutive data_in_vld, first with data_first=1, data_in=128'h0 -> outputs K10,K9..K0; round_idx_out 10..0; block_done only with the K0 output.
- data_in_vld before any keys load, data_in=128'hFFFF...F -> block_data_out=0, vld=1, key_miss=1.
- key_load_start after 4 states of a block -> keys_loaded=0, no block_done; reload, new block starts at key 10.
- data_first=1 issued at rd_idx=5 -> that output uses K10 and the sequence continues 9..0.
- Assert rst mid-block, release, then issue data_in_vld -> key_miss=1, keys must be reloaded.
